stopwatch_ctrl: RTL and testbench

Stopwatch controller that consumes one-cycle button-press event flags from the input synchronizer stage and runs a two-digit BCD seconds counter (00–99) for the timed display. It sits directly downstream of the synchronizer: its reset is the synchronized reset, and its press inputs are the synchronized falling-edge flags. It drives the 7-segment decoder stage with BCD digits, a run indicator and a per-increment tick pulse.

---
 rtl/stopwatch_ctrl_if.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - press-event and display bundle around the stopwatch controller
// Purpose: groups the synchronized press events going into the stopwatch and the
//          BCD/run/tick signals going out to the 7-segment decoder stage.
// Signals:
//   start_stop_pressed : one-cycle start/stop press event
//   clear_pressed      : one-cycle clear press event
//   count_ones         : BCD units digit
//   count_tens         : BCD tens digit
//   running            : high while the stopwatch is running
//   tick               : one-cycle pulse on every count increment
// Modports: master drives presses and observes the display, slave is the stopwatch.
interface stopwatch_ctrl_if;
  logic       start_stop_pressed;
  logic       clear_pressed;
  logic [3:0] count_ones;
  logic [3:0] count_tens;
  logic       running;
  logic       tick;

  modport master (
    output start_stop_pressed,
    output clear_pressed,
    input  count_ones,
    input  count_tens,
    input  running,
    input  tick
  );

  modport slave (
    input  start_stop_pressed,
    input  clear_pressed,
    output count_ones,
    output count_tens,
    output running,
    output tick
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - two-digit BCD seconds stopwatch with start/stop and clear
// Purpose: IDLE/RUNNING/PAUSED controller with a TICK_DIV prescaler driving a
//          00..99 wrapping BCD counter; all outputs registered.
// Ports:
//   clock   : source clock
//   reset_n : asynchronous active-low reset (synchronized reset upstream)
//   bus     : stopwatch_ctrl_if.slave (press events in, digits/running/tick out)
// Option: define STOPWATCH_LOCKOUT_EN to ignore start/stop presses for
//         LOCKOUT_CYCLES cycles after each accepted one.
module stopwatch_ctrl #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int LOCKOUT_CYCLES = 5_000_000
) (
  input  logic            clock,
  input  logic            reset_n,
  stopwatch_ctrl_if.slave bus
);
  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ps, w_ps_nxt;
  logic [3:0]    r_ones, w_ones_nxt;
  logic [3:0]    r_tens, w_tens_nxt;
  logic          r_running;
  logic          r_tick, w_tick_nxt;
  logic          w_ss;

`ifdef STOPWATCH_LOCKOUT_EN
  localparam int            LW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  logic [LW-1:0] r_lock, w_lock_nxt;

  // A start/stop press only counts once the previous one's lockout has drained.
  assign w_ss = bus.start_stop_pressed && (r_lock == '0);

  always_comb begin
    w_lock_nxt = (r_lock != '0) ? r_lock - LW'(1) : r_lock;
    if (bus.clear_pressed) begin
      w_lock_nxt = '0;
    end else if (w_ss) begin
      w_lock_nxt = LOCK_LOAD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock <= '0;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end
`else
  logic w_unused_lockout;
  assign w_unused_lockout = (LOCKOUT_CYCLES != 0);
  assign w_ss             = bus.start_stop_pressed;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ps_nxt    = r_ps;
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    w_tick_nxt  = 1'b0;
    // Clear overrides everything, including a simultaneous start/stop press.
    if (bus.clear_pressed) begin
      w_state_nxt = S_IDLE;
      w_ps_nxt    = '0;
      w_ones_nxt  = 4'd0;
      w_tens_nxt  = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ps_nxt = '0;
          if (w_ss) begin
            w_state_nxt = S_RUNNING;
          end
        end
        S_RUNNING: begin
          // The increment still happens when a pause lands on the wrap cycle.
          if (r_ps == PS_LAST) begin
            w_ps_nxt   = '0;
            w_tick_nxt = 1'b1;
            if (r_ones == 4'd9) begin
              w_ones_nxt = 4'd0;
              w_tens_nxt = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
            end else begin
              w_ones_nxt = r_ones + 4'd1;
            end
          end else begin
            w_ps_nxt = r_ps + PW'(1);
          end
          if (w_ss) begin
            w_state_nxt = S_PAUSED;
          end
        end
        S_PAUSED: begin
          // Prescaler holds, so paused time is not counted on resume.
          if (w_ss) begin
            w_state_nxt = S_RUNNING;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ps      <= '0;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ps      <= w_ps_nxt;
      r_ones    <= w_ones_nxt;
      r_tens    <= w_tens_nxt;
      r_running <= (w_state_nxt == S_RUNNING);
      r_tick    <= w_tick_nxt;
    end
  end

  assign bus.count_ones = r_ones;
  assign bus.count_tens = r_tens;
  assign bus.running    = r_running;
  assign bus.tick       = r_tick;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against an elapsed-time model
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int LC = 8;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic clock;
  logic reset_n;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV      (TD),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (sw_if)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  bit prev_tick = 0;

  // Model: the displayed count is simply the number of running cycles since the
  // last clear/reset, divided by TD, modulo 100.
  int m_mode    = M_IDLE;
  int m_elapsed = 0;
  bit m_tick    = 0;
  int m_lock    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_count();
    return (m_elapsed / TD) % 100;
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_tick    = 0;
    m_lock    = 0;
  endtask

  task automatic model_update(input bit ss, input bit clr);
    bit acc;
    if (clr) begin
      model_reset();
    end else begin
`ifdef STOPWATCH_LOCKOUT_EN
      acc = ss && (m_lock == 0);
      if (m_lock > 0) m_lock--;
      if (acc) m_lock = LC - 1;
`else
      acc = ss;
`endif
      m_tick = 0;
      if (m_mode == M_RUN) begin
        m_elapsed++;
        m_tick = ((m_elapsed % TD) == 0);
      end
      if (acc) m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
    end
  endtask

  // Single compare process: outputs against the model on every cycle out of reset.
  always @(posedge clock) begin
    #2;
    if (chk_en && reset_n) begin
      chk("ones", int'(sw_if.count_ones), exp_count() % 10);
      chk("tens", int'(sw_if.count_tens), exp_count() / 10);
      chk("running", int'(sw_if.running), int'(m_mode == M_RUN));
      chk("tick", int'(sw_if.tick), int'(m_tick));
      chk("tick_pair", int'(prev_tick && sw_if.tick), 0);
      prev_tick <= sw_if.tick;
    end else begin
      prev_tick <= 1'b0;
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit ss, input bit clr);
    sw_if.start_stop_pressed = ss;
    sw_if.clear_pressed      = clr;
    @(posedge clock);
    model_update(ss, clr);
    @(negedge clock);
    sw_if.start_stop_pressed = 1'b0;
    sw_if.clear_pressed      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    sw_if.start_stop_pressed = 1'b0;
    sw_if.clear_pressed      = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_ones", int'(sw_if.count_ones), 0);
    chk("areset_tens", int'(sw_if.count_tens), 0);
    chk("areset_running", int'(sw_if.running), 0);
    chk("areset_tick", int'(sw_if.tick), 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n                  = 1'b0;
    sw_if.start_stop_pressed = 1'b0;
    sw_if.clear_pressed      = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_ones", int'(sw_if.count_ones), 0);
    chk("rst_tens", int'(sw_if.count_tens), 0);
    chk("rst_running", int'(sw_if.running), 0);
    chk("rst_tick", int'(sw_if.tick), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Start, first and second increments.
    step(1'b1, 1'b0);
    chk("start_running", int'(sw_if.running), 1);
    run(3);
    chk("pre_tick", int'(sw_if.tick), 0);
    step(1'b0, 1'b0);
    chk("first_tick", int'(sw_if.tick), 1);
    chk("first_ones", int'(sw_if.count_ones), 1);
    run(4);
    chk("second_ones", int'(sw_if.count_ones), 2);

    // 09 -> 10 and 99 -> 00.
    run(28);
    chk("nine_ones", int'(sw_if.count_ones), 9);
    chk("nine_tens", int'(sw_if.count_tens), 0);
    run(4);
    chk("ten_ones", int'(sw_if.count_ones), 0);
    chk("ten_tens", int'(sw_if.count_tens), 1);
    run(4 * 89);
    chk("n99_ones", int'(sw_if.count_ones), 9);
    chk("n99_tens", int'(sw_if.count_tens), 9);
    run(4);
    chk("wrap_ones", int'(sw_if.count_ones), 0);
    chk("wrap_tens", int'(sw_if.count_tens), 0);
    chk("wrap_running", int'(sw_if.running), 1);

    // Pause and resume: prescaler holds its partial value.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
`ifdef STOPWATCH_LOCKOUT_EN
    run(9);
    step(1'b1, 1'b0);
    chk("paused_ones", int'(sw_if.count_ones), 2);
    run(20);
    chk("paused_hold", int'(sw_if.count_ones), 2);
`else
    run(1);
    step(1'b1, 1'b0);
    chk("paused_ones", int'(sw_if.count_ones), 0);
    run(20);
    chk("paused_hold", int'(sw_if.count_ones), 0);
`endif
    chk("paused_running", int'(sw_if.running), 0);
    step(1'b1, 1'b0);
    chk("resume_running", int'(sw_if.running), 1);
    step(1'b0, 1'b0);
    chk("resume_no_tick", int'(sw_if.tick), 0);
    step(1'b0, 1'b0);
    chk("resume_tick", int'(sw_if.tick), 1);

    // Clear plus start together at 05.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run(20);
    chk("five_ones", int'(sw_if.count_ones), 5);
    step(1'b1, 1'b1);
    chk("clr_ones", int'(sw_if.count_ones), 0);
    chk("clr_running", int'(sw_if.running), 0);
    step(1'b1, 1'b0);
    run(3);
    chk("clr_pre_tick", int'(sw_if.tick), 0);
    step(1'b0, 1'b0);
    chk("clr_first_tick", int'(sw_if.tick), 1);

    // Asynchronous reset at 37, then idle until a start.
    run(144);
    chk("n37_tens", int'(sw_if.count_tens), 3);
    chk("n37_ones", int'(sw_if.count_ones), 7);
    mid_reset();
    run(10);
    chk("post_rst_running", int'(sw_if.running), 0);
    chk("post_rst_ones", int'(sw_if.count_ones), 0);

    // Lockout window: presses 3 and 9 cycles after the start.
    step(1'b1, 1'b0);
    run(2);
    step(1'b1, 1'b0);
`ifdef STOPWATCH_LOCKOUT_EN
    chk("lock_ignored", int'(sw_if.running), 1);
`else
    chk("nolock_paused", int'(sw_if.running), 0);
`endif
    run(5);
    step(1'b1, 1'b0);
`ifdef STOPWATCH_LOCKOUT_EN
    chk("lock_paused", int'(sw_if.running), 0);
`else
    chk("nolock_resumed", int'(sw_if.running), 1);
`endif

    // Randomized presses, clears and occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
      end else begin
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
      end
    end

    chk_en = 1'b0;
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
